// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Sequencer for a bit-serial subtractor. Accepts two WIDTH-bit operands and
//   a borrow-in, then runs a single full-subtractor slice LSB-first for WIDTH
//   cycles with the running borrow held in a flop. Results are registered and
//   held until the next completion. Used in place of a WIDTH-wide ripple
//   subtractor where area matters more than latency.
//
// Ports
//   clk    in   rising-edge system clock
//   rst    in   asynchronous, active-high reset
//   start  in   request, sampled only in IDLE
//   a      in   minuend, sampled at the accepting edge
//   b      in   subtrahend, sampled at the accepting edge
//   bin    in   borrow-in, sampled at the accepting edge
//   busy   out  high in RUN and DONE
//   done   out  one-cycle completion pulse
//   diff   out  registered a - b - bin, modulo 2^WIDTH
//   bout   out  registered borrow-out (a < b + bin, unsigned)
//   zero   out  registered diff == 0
//   ovf    out  registered signed overflow of the subtraction
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   // Only WIDTH-1 result bits need storage: the bit produced on the final
   // edge goes straight into diff together with the stored ones.
   logic [WIDTH-2:0] sd;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic             d;
   logic             nb;
   logic [WIDTH-1:0] sd_nx;
   logic             last;

   // One full-subtractor slice: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      logic dbit;
      logic bo;
      dbit = x ^ y ^ bi;
      bo   = (~x & y) | (y & bi) | (~x & bi);
      return {bo, dbit};
   endfunction

   always_comb begin
      {nb, d} = full_sub(sa[0], sb[0], br);
      sd_nx   = {d, sd};
      last    = (cnt == CW'(WIDTH - 1));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and handshake decode; busy/done depend only on the state
   // register, so there is no input-to-output combinational path.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Operand load, serial slice and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         sd    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sd    <= '0;
                  br    <= bin;
                  cnt   <= '0;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
               end
            end
            RUN: begin
               sa <= sa >> 1;
               sb <= sb >> 1;
               sd <= sd_nx[WIDTH-1:1];
               br <= nb;
               if (last) begin
                  // Counter is cleared rather than incremented so it never
                  // wraps when WIDTH is a power of two.
                  cnt  <= '0;
                  diff <= sd_nx;
                  bout <= nb;
                  zero <= (sd_nx == '0);
                  // d is the final diff MSB.
                  ovf  <= (a_msb != b_msb) && (d != a_msb);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Scoreboard bench for serial_sub_ctrl with one WIDTH=8 and one WIDTH=3
//   instance. Expected results are queued when a start is presented at an
//   edge the bench knows to be accepting, and popped when done is seen.
module tb_serial_sub_ctrl;

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      logic        zero;
      logic        ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8, bin8, busy8, done8, bout8, zero8, ovf8;
   logic [7:0] a8, b8, diff8;
   logic       start3, bin3, busy3, done3, bout3, zero3, ovf3;
   logic [2:0] a3, b3, diff3;

   exp_t q8[$];
   exp_t q3[$];
   exp_t e8, e3;

   int checks   = 0;
   int failures = 0;
   int dones8   = 0;
   int dones3   = 0;
   int pushed8  = 0;
   int pushed3  = 0;
   int dropped8 = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
   );

   serial_sub_ctrl #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
      .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .zero(zero3), .ovf(ovf3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {bout, diff} = a - b - bin computed one bit wider than w.
   function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic bi);
      exp_t        r;
      logic [32:0] mask;
      logic [32:0] t;
      mask   = (33'd1 << w) - 33'd1;
      t      = ({1'b0, av} & mask) - ({1'b0, bv} & mask) - {32'd0, bi};
      r.diff = 32'(t & mask);
      r.bout = t[w];
      r.zero = (r.diff == 32'd0);
      r.ovf  = (av[w-1] != bv[w-1]) && (r.diff[w-1] != av[w-1]);
      return r;
   endfunction

   // Bench actions happen 2 time units after the edge; monitors at 1.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (done8 === 1'b1) begin
         dones8++;
         if (q8.size() == 0) begin
            chk("unexpected_done8", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            chk("diff8", {24'd0, diff8}, e8.diff);
            chk("bout8", {31'd0, bout8}, {31'd0, e8.bout});
            chk("zero8", {31'd0, zero8}, {31'd0, e8.zero});
            chk("ovf8",  {31'd0, ovf8},  {31'd0, e8.ovf});
         end
      end
      if (done3 === 1'b1) begin
         dones3++;
         if (q3.size() == 0) begin
            chk("unexpected_done3", 32'd1, 32'd0);
         end else begin
            e3 = q3.pop_front();
            chk("diff3", {29'd0, diff3}, e3.diff);
            chk("bout3", {31'd0, bout3}, {31'd0, e3.bout});
            chk("zero3", {31'd0, zero3}, {31'd0, e3.zero});
            chk("ovf3",  {31'd0, ovf3},  {31'd0, e3.ovf});
         end
      end
   end

   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
      q8.push_back(model(8, {24'd0, av}, {24'd0, bv}, bi));
      pushed8++;
      tick();
      // Operands change during RUN; they must not affect the result.
      start8 = 1'b0; a8 = ~av; b8 = 8'($urandom); bin8 = ~bi;
      for (int i = 0; i < 20 && q8.size() != 0; i++) tick();
      chk("drain8", q8.size(), 32'd0);
      tick();
   endtask

   task automatic op3(input logic [2:0] av, input logic [2:0] bv, input logic bi);
      a3 = av; b3 = bv; bin3 = bi; start3 = 1'b1;
      q3.push_back(model(3, {29'd0, av}, {29'd0, bv}, bi));
      pushed3++;
      tick();
      start3 = 1'b0; a3 = ~av; b3 = 3'($urandom); bin3 = ~bi;
      for (int i = 0; i < 12 && q3.size() != 0; i++) tick();
      chk("drain3", q3.size(), 32'd0);
      tick();
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_busy8"}, {31'd0, busy8}, 32'd0);
      chk({tag, "_done8"}, {31'd0, done8}, 32'd0);
      chk({tag, "_diff8"}, {24'd0, diff8}, 32'd0);
      chk({tag, "_bout8"}, {31'd0, bout8}, 32'd0);
      chk({tag, "_zero8"}, {31'd0, zero8}, 32'd0);
      chk({tag, "_ovf8"},  {31'd0, ovf8},  32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
      repeat (3) tick();
      chk_outs_zero("reset");
      chk("reset_busy3", {31'd0, busy3}, 32'd0);
      chk("reset_diff3", {29'd0, diff3}, 32'd0);
      rst = 1'b0;
      tick();

      // Handshake timing for 0x5A - 0x3C: busy 9 cycles, done after edge 8.
      a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
      q8.push_back(model(8, 32'h5A, 32'h3C, 1'b0));
      pushed8++;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 0) begin
            start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
         end
         chk($sformatf("t1_busy_e%0d", k), {31'd0, busy8}, (k < 9) ? 32'd1 : 32'd0);
         chk($sformatf("t1_done_e%0d", k), {31'd0, done8}, (k == 8) ? 32'd1 : 32'd0);
      end
      chk("t1_diff_const", {24'd0, diff8}, 32'h1E);
      chk("t1_drain", q8.size(), 32'd0);

      // Directed boundary cases
      op8(8'h00, 8'h01, 1'b0);
      op8(8'h80, 8'h01, 1'b0);
      op8(8'h10, 8'h0F, 1'b1);
      op8(8'h33, 8'h33, 1'b1);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'h7F, 8'h80, 1'b1);

      // start held high, operands changing every cycle: one op per 10 cycles.
      for (int k = 0; k < 50; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'b1;
         if (k % 10 == 0) begin
            q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, bin8));
            pushed8++;
         end
         tick();
      end
      start8 = 1'b0;
      for (int i = 0; i < 20 && q8.size() != 0; i++) tick();
      chk("b2b_drain", q8.size(), 32'd0);
      tick();

      // Asynchronous reset mid-RUN discards the operation.
      op8(8'h5A, 8'h3C, 1'b0);
      a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      q8.push_back(model(8, 32'hFF, 32'h01, 1'b0));
      pushed8++;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk_outs_zero("midrst");
      q8.delete();
      dropped8++;
      d0 = dones8;
      repeat (2) tick();
      rst = 1'b0;
      repeat (12) tick();
      chk("midrst_no_done", dones8, d0);
      chk("midrst_idle", {31'd0, busy8}, 32'd0);
      op8(8'hFF, 8'h01, 1'b0);

      // Random sweeps
      repeat (40) op8(8'($urandom), 8'($urandom), 1'($urandom));
      op3(3'd0, 3'd1, 1'b0);
      op3(3'd4, 3'd1, 1'b0);
      op3(3'd2, 3'd1, 1'b1);
      repeat (30) op3(3'($urandom), 3'($urandom), 1'($urandom));

      chk("dones8", dones8, pushed8 - dropped8);
      chk("dones3", dones3, pushed3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
